// File: rtl/pixel_writer_if.sv
// Memory-side write bus for pixel_writer (Avalon-MM style, write-only).
//   mem_write       request; held together with address/data while
//                   mem_waitrequest is high
//   mem_address     28-bit byte address
//   mem_writedata   32-bit write data
//   mem_byteenable  byte lanes in use
//   mem_waitrequest slave back-pressure
// Modports: master = pixel_writer, slave = memory interconnect.
interface pixel_writer_if;
  logic        mem_write;
  logic [27:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;

  modport master (
    output mem_write, mem_address, mem_writedata, mem_byteenable,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_write, mem_address, mem_writedata, mem_byteenable,
    output mem_waitrequest
  );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer: framebuffer write stage behind the rasterizer.
// Buffers shaded pixels in a FIFO and drains them as single 32-bit
// writes; pulses done_out once a batch is completely written.
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   pix_valid/addr/color   pixel input (word index + 24-bit RGB)
//   done_in                end-of-batch level from upstream
//   stall_out              upstream must stop issuing pixels
//   done_out               one-cycle pulse after the last write is accepted
//   overflow               sticky: a pixel was dropped on a full FIFO
//   mem                    memory write bus (pixel_writer_if.master)
//   pix_count              accepted-write counter, only with the
//                          PIXEL_WRITER_STATS_EN macro defined
module pixel_writer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SKID    = 2,
  parameter logic [27:0] FB_BASE = 28'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pix_valid,
  input  logic [25:0]         pix_addr,
  input  logic [23:0]         pix_color,
  input  logic                done_in,
  output logic                stall_out,
  output logic                done_out,
  output logic                overflow,
  pixel_writer_if.master      mem
`ifdef PIXEL_WRITER_STATS_EN
  ,
  output logic [31:0]         pix_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - SKID);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic          armed;
  logic [49:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [49:0]   head;
  logic          out_valid;
  logic [27:0]   out_addr;
  logic [31:0]   out_data;

  logic full, empty, push, pop, accept;

  assign head   = fifo_mem[rd_ptr];
  assign full   = (count == FULL_LVL);
  assign empty  = (count == '0);
  assign push   = pix_valid && !full && (state == S_RUN);
  assign accept = out_valid && !mem.mem_waitrequest;
  // Output register refills whenever it is free or emptying this cycle.
  assign pop    = !empty && (!out_valid || accept);

  assign stall_out          = (count >= STALL_LVL) || (state != S_RUN);
  assign mem.mem_write      = out_valid;
  assign mem.mem_address    = out_addr;
  assign mem.mem_writedata  = out_data;
  assign mem.mem_byteenable = out_valid ? 4'b0111 : 4'b0000;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {pix_addr, pix_color};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
        out_addr  <= FB_BASE + {head[49:24], 2'b00};
        out_data  <= {8'h00, head[23:0]};
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pix_valid && full) overflow <= 1'b1;
    end
  end

  // armed re-opens done_in detection only after done_in has been seen low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      armed    <= 1'b1;
      done_out <= 1'b0;
    end else begin
      if (!done_in) armed <= 1'b1;
      case (state)
        S_RUN: begin
          done_out <= 1'b0;
          if (done_in && armed) begin
            state <= S_DRAIN;
            armed <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Leave as soon as the final write is accepted so done_out
          // appears in the very next cycle.
          if (empty && (!out_valid || accept)) begin
            state    <= S_DONE;
            done_out <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_RUN;
          done_out <= 1'b0;
        end
        default: begin
          state    <= S_RUN;
          done_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIXEL_WRITER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      pix_count <= '0;
    else if (accept) pix_count <= pix_count + 32'd1;
  end
`endif

endmodule
